store_rmw_unit: RTL
===================

Name: store_rmw_unit

Overview:
- Store-side counterpart to the immediate/load extender: narrows a 32-bit register value to byte, halfword or word width and writes it into word-organised data memory.
- Subword stores use a read-modify-write sequence: read the word, merge the lane, write it back.
- Sits between the datapath store port and a synchronous single-port data RAM.
- Byte lanes are big-endian, consistent with the MIPS datapath.

Parameters:
- ADDR_W, 10, word-address width of the data RAM; byte address bits [ADDR_W+1:2] are used.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  32  byte address.
- req_data  input  32  store data; the narrow value is in the LSBs.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; request rejected, no memory write.
- mem_addr  output  ADDR_W  RAM word address.
- mem_re  output  1  RAM read enable; rdata is valid the following cycle.
- mem_rdata  input  32  RAM read data.
- mem_we  output  1  RAM write enable, full word.
- mem_wdata  output  32  RAM write data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - done, err, mem_re, mem_we, mem_addr and mem_wdata all go to 0.
  - req_ready is forced to 0 while rst_n is low.
  - Latched request registers are cleared.
- States: IDLE, READ, MERGE, WRITE, RESP. All outputs are registered or decoded from state only; there is no combinational path from req_* to mem_*.
- IDLE:
  - req_ready = 1.
  - A handshake completes when req_valid && req_ready at a rising edge. The unit then latches addr, data and size, and req_ready drops.
- Alignment check, done at acceptance:
  - Misaligned when size = 01 and addr[0] = 1, or size = 10 and addr[1:0] != 0, or size = 11.
  - Misaligned requests go to RESP with err = 1; no mem_re or mem_we is ever asserted.
- Word store: goes directly to WRITE; mem_wdata = req_data.
- Subword store sequence:
  - READ: mem_re = 1 and mem_addr = addr[ADDR_W+1:2] for exactly one cycle.
  - MERGE: capture mem_rdata and replace one lane.
    - Byte at offset 0/1/2/3 replaces bits [31:24]/[23:16]/[15:8]/[7:0] with req_data[7:0].
    - Halfword at offset 0/2 replaces [31:16]/[15:0] with req_data[15:0].
    - All other bits are preserved exactly.
  - WRITE: mem_we = 1 for exactly one cycle, with mem_addr and mem_wdata held stable.
- RESP: done = 1 for one cycle (err as determined above), then return to IDLE. req_ready is 1 again in the cycle after RESP.
- Latency from the acceptance edge T, with states entered at the listed edges:
  - Word: WRITE at T+1, done high during the cycle after T+2.
  - Subword: READ at T+1, MERGE at T+2, WRITE at T+3, RESP at T+4.
  - Error: RESP at T+1.
- Request inputs are ignored outside IDLE. No new request is accepted in the RESP cycle.
- Address bits above ADDR_W+1 are ignored; the address wraps modulo RAM size.
- Reset in any state aborts the operation.
  - Reset asserted in WRITE deasserts mem_we immediately (asynchronously). Whether the RAM captures that partial cycle is the RAM's concern.
  - No done is produced for the aborted request.
- mem_re and mem_we are never high in the same cycle.

Test Plan:
- Word store: addr 0x0000_0010, data 0xDEADBEEF, size 10 -> mem_we one cycle at word address 4 with wdata 0xDEADBEEF; no mem_re; done at T+2, err 0.
- Byte merge: RAM word 3 = 0x11223344; store byte 0xAA to addr 0x0D (offset 1) -> mem_re at word 3, then mem_we wdata 0x11AA3344; done at T+4. Repeat for offsets 0, 2, 3, expecting 0xAA223344, 0x1122AA44, 0x112233AA.
- Halfword merge: RAM word 0 = 0xCAFEF00D; store 0x00001234 size 01 at addr 0x2 -> wdata 0xCAFE1234. At addr 0x0 -> wdata 0x1234F00D.
- Misaligned and illegal cases:
  - Halfword at addr 0x3 -> done and err = 1 at T+1, no mem_re or mem_we.
  - Word at addr 0x6 -> same response.
  - size 11 at addr 0x0 -> same response.
- Back-to-back: hold req_valid high with two byte stores -> second accepted only when req_ready returns after RESP; the RAM shows both merges in order; req_data changes mid-operation have no effect.
- Reset mid-operation: assert rst_n low while in MERGE -> mem_we, mem_re, done and req_ready drop to 0 immediately; RAM is unchanged. After release, req_ready = 1 and a new word store completes normally.

Source files
------------

// File: rtl/store_rmw_if.sv
// Store request / data-RAM bundle between the datapath store port, store_rmw_unit and the RAM.
// The unit connects through the slave modport; the requester/RAM side uses master.
interface store_rmw_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Narrows a register value to byte/halfword/word and stores it into word-organised RAM,
// using read-modify-write for subword stores. Big-endian byte lanes.
//
// state   | meaning
// IDLE    | ready for a request; latches it and checks alignment on handshake
// READ    | mem_re high for one cycle at the latched word address
// MERGE   | mem_rdata valid; replace one lane into the write-data register
// WRITE   | mem_we high for one cycle, address and data held stable
// RESP    | done pulse (with err for rejected requests)
module store_rmw_unit #(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  store_rmw_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic              r_half;
  logic [15:0]       r_data;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_misalign;
  logic [31:0]       w_merged;
  logic              w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      2'b01:   w_misalign = bus.req_addr[0];
      2'b10:   w_misalign = (bus.req_addr[1:0] != 2'b00);
      2'b11:   w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Offset 0 is the most significant lane (big-endian).
  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_half) begin
      if (r_off[1]) w_merged[15:0]  = r_data;
      else          w_merged[31:16] = r_data;
    end else begin
      case (r_off)
        2'd0:    w_merged[31:24] = r_data[7:0];
        2'd1:    w_merged[23:16] = r_data[7:0];
        2'd2:    w_merged[15:8]  = r_data[7:0];
        default: w_merged[7:0]   = r_data[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_off   <= '0;
      r_half  <= 1'b0;
      r_data  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr[ADDR_W+1:2];
            r_off   <= bus.req_addr[1:0];
            r_half  <= bus.req_size[0];
            r_data  <= bus.req_data[15:0];
            r_wdata <= bus.req_data;
            r_err   <= w_misalign;
            if (w_misalign)                r_state <= S_RESP;
            else if (bus.req_size == 2'b10) r_state <= S_WRITE;
            else                            r_state <= S_READ;
          end
        end
        S_READ:  r_state <= S_MERGE;
        S_MERGE: begin
          r_wdata <= w_merged;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign bus.req_ready = rst_n && (r_state == S_IDLE);
  assign bus.mem_re    = (r_state == S_READ);
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.done      = (r_state == S_RESP);
  assign bus.err       = (r_state == S_RESP) && r_err;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule
